// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with self-clearing after reset
// Reads are masked to zero until the clear sweep finishes; writes during the sweep are dropped.
module regfile_mp #(
  parameter  int XLEN    = 32,
  parameter  int NREGS   = 32,
  parameter  int NRD     = 2,
  parameter  int BYPASS  = 1,
  parameter  int ZERO_R0 = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  output logic                ready,
  output logic                wr_drop
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ready_q, ready_d;
  logic            wr_drop_q, wr_drop_d;
  logic [XLEN-1:0] mem_q [NREGS];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
    wr_drop_d = 1'b0;
    case (state_q)
      CLEAR: begin
        wr_drop_d = wr_en;
        if (ptr_q == AW'(NREGS - 1)) begin
          state_d = READY;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      READY:   ;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end else if (wr_en && !(ZERO_R0 != 0 && wr_addr == '0)) begin
      mem_we = 1'b1;
    end
  end

  // Zero-register masking takes priority over the write bypass.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (state_q == READY) begin
        if (ZERO_R0 != 0 && rd_addr[i*AW +: AW] == '0)
          rd_data[i*XLEN +: XLEN] = '0;
        else if (BYPASS != 0 && wr_en && rd_addr[i*AW +: AW] == wr_addr)
          rd_data[i*XLEN +: XLEN] = wr_data;
        else
          rd_data[i*XLEN +: XLEN] = mem_q[rd_addr[i*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we)
      mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready   = ready_q;
  assign wr_drop = wr_drop_q;

endmodule
